// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Bundles the requester-side request/data lines and the
//            transmitter-side start/data/busy lines of the UART TX arbiter.
//            The master modport is the environment (clients + serializer),
//            the slave modport is the arbiter itself.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();

  localparam int c_ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    active;
  logic [c_ID_W-1:0]       cur_id;
  logic                    err_timeout;

  // Clients and the serializer drive requests and busy, observe the rest
  modport master (
    output req, req_data, tx_busy,
    input  gnt, tx_start, tx_data, active, cur_id, err_timeout
  );

  // The arbiter consumes requests and busy, drives grants and the TX side
  modport slave (
    input  req, req_data, tx_busy,
    output gnt, tx_start, tx_data, active, cur_id, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one byte-wide UART transmitter among
//            N_REQ clients. One byte is accepted per grant, a single-cycle
//            tx_start is issued, and the frame is tracked through tx_busy.
//            A transmitter that never raises busy is abandoned after
//            BUSY_TIMEOUT cycles with a one-cycle err_timeout pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int c_ID_W  = $clog2(N_REQ);
  localparam int c_CNT_W = $clog2(BUSY_TIMEOUT);

  // Counter value on which the busy wait is declared lost
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [c_ID_W-1:0]  c_ID_LAST = c_ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [N_REQ-1:0]     r_gnt;
  logic                 r_tx_start;
  logic [DATA_W-1:0]    r_tx_data;
  logic                 r_active;
  logic [c_ID_W-1:0]    r_cur_id;
  logic                 r_err_timeout;
  logic [c_ID_W-1:0]    r_rr_ptr;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_any;
  logic [c_ID_W-1:0]    w_sel;
  logic [N_REQ-1:0]     w_gnt;
  logic [DATA_W-1:0]    w_data;
  logic [c_ID_W-1:0]    w_next_ptr;

  // Rotating priority search: the first requester at or after r_rr_ptr wins.
  // Both loops unroll to constant indices so no variable bit-select is needed.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_gnt  = '0;
    w_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any && bus.req[i] && (((int'(r_rr_ptr) + k) % N_REQ) == i)) begin
          w_any    = 1'b1;
          w_sel    = c_ID_W'(i);
          w_gnt[i] = 1'b1;
          w_data   = bus.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // The served requester drops to lowest priority once its frame is closed
  always_comb begin
    w_next_ptr = (r_cur_id == c_ID_LAST) ? '0 : r_cur_id + c_ID_W'(1);
  end

  // Frame sequencer; every output is a register written here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_active      <= 1'b0;
      r_cur_id      <= '0;
      r_err_timeout <= 1'b0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
    end else begin
      // Pulsed outputs default low; only the owning state raises them
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_err_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A busy transmitter here belongs to someone else; never collide
          if (!bus.tx_busy && w_any) begin
            r_gnt     <= w_gnt;
            r_tx_data <= w_data;
            r_cur_id  <= w_sel;
            r_active  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_tx_start <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == c_TO_LAST) begin
            // Byte is dropped: the client already saw its grant, no retry
            r_err_timeout <= 1'b1;
            r_rr_ptr      <= w_next_ptr;
            r_active      <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_rr_ptr <= w_next_ptr;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.active      = r_active;
  assign bus.cur_id      = r_cur_id;
  assign bus.err_timeout = r_err_timeout;

  // Structural invariants of the grant/start outputs
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
                                  $onehot0(r_gnt));
  a_gnt_start_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                      !((|r_gnt) && r_tx_start));

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed bench for uart_tx_arbiter: a cycle table of inputs and
//            expected registered outputs, plus hand sequences for timeout,
//            continuous round-robin and reset during a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 16;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       busy;
    int         n;
    logic [3:0] gnt;
    logic       start;
    logic [7:0] data;
    logic       act;
    logic [1:0] id;
    logic       err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.tx_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One round-robin service: wait for the grant, check it, run a short frame
  task automatic serve(input int id, input logic [7:0] b);
    int cyc = 0;
    while (bus.gnt == 4'b0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk($sformatf("rr_gnt_%0d", id), 32'(bus.gnt), 32'(4'b0001 << id));
    chk($sformatf("rr_id_%0d", id), 32'(bus.cur_id), 32'(id));
    step();
    chk($sformatf("rr_start_%0d", id), 32'({bus.gnt, bus.tx_start}), 32'(5'b00001));
    chk($sformatf("rr_data_%0d", id), 32'(bus.tx_data), 32'(b));
    bus.tx_busy = 1'b1;
    repeat (4) step();
    bus.tx_busy = 1'b0;
    step();
  endtask

  initial begin
    int k;
    int extra_starts;

    rst_n        = 1'b0;
    bus.req      = '0;
    bus.tx_busy  = 1'b0;
    bus.req_data = {8'h13, 8'h12, 8'hA5, 8'h10};

    // rst, req, busy, n | gnt, start, data, act, id, err
    vt.push_back('{1'b0, 4'b0000, 1'b0,  2, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'b0010, 1'b0,  1, 4'b0010, 1'b0, 8'hA5, 1'b1, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b1, 20, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  2, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd1, 1'b0});
    // serve requester 2, then 0 and 2 contend with the pointer at 3
    vt.push_back('{1'b1, 4'b0100, 1'b0,  1, 4'b0100, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b1, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b1,  3, 4'b0000, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b0, 8'h12, 1'b0, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0101, 1'b0,  1, 4'b0001, 1'b0, 8'h10, 1'b1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 1'b0,  1, 4'b0000, 1'b1, 8'h10, 1'b1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 1'b1,  2, 4'b0000, 1'b0, 8'h10, 1'b1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 1'b0,  1, 4'b0000, 1'b0, 8'h10, 1'b0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 1'b0,  1, 4'b0100, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b1, 8'h12, 1'b1, 2'd2, 1'b0});
    // one-cycle busy pulse inside the busy wait: rise then fall
    vt.push_back('{1'b1, 4'b0000, 1'b1,  1, 4'b0000, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b0, 8'h12, 1'b0, 2'd2, 1'b0});
    // busy while idle blocks the grant until it drops
    vt.push_back('{1'b1, 4'b0100, 1'b1,  3, 4'b0000, 1'b0, 8'h12, 1'b0, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 1'b0,  1, 4'b0100, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b1,  1, 4'b0000, 1'b1, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b1,  1, 4'b0000, 1'b0, 8'h12, 1'b1, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'b0000, 1'b0,  1, 4'b0000, 1'b0, 8'h12, 1'b0, 2'd2, 1'b0});

    foreach (vt[v]) begin
      for (int c = 0; c < vt[v].n; c++) begin
        rst_n       = vt[v].rst_n;
        bus.req     = vt[v].req;
        bus.tx_busy = vt[v].busy;
        step();
        chk($sformatf("vec%0d_c%0d{gnt,start,data,act,id,err}", v, c),
            32'({bus.gnt, bus.tx_start, bus.tx_data, bus.active, bus.cur_id, bus.err_timeout}),
            32'({vt[v].gnt, vt[v].start, vt[v].data, vt[v].act, vt[v].id, vt[v].err}));
      end
    end

    // Timeout: busy never rises
    do_reset();
    bus.req = 4'b0001;
    step();
    chk("to_gnt", 32'(bus.gnt), 32'(4'b0001));
    bus.req = 4'b0000;
    step();
    chk("to_start", 32'(bus.tx_start), 32'(1));
    k = 0;
    extra_starts = 0;
    while (k < 40) begin
      step();
      k++;
      if (bus.tx_start) extra_starts++;
      if (bus.err_timeout) break;
    end
    chk("to_latency", 32'(k), 32'(BUSY_TIMEOUT));
    chk("to_active_low", 32'(bus.active), 32'(0));
    chk("to_extra_starts", 32'(extra_starts), 32'(0));
    bus.req = 4'b0011;
    step();
    chk("to_err_pulse_end", 32'(bus.err_timeout), 32'(0));
    chk("to_next_scan_from_1", 32'(bus.gnt), 32'(4'b0010));

    // Round-robin with all requesters held high
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req      = 4'b1111;
    serve(0, 8'h10);
    serve(1, 8'h11);
    serve(2, 8'h12);
    serve(3, 8'h13);
    serve(0, 8'h10);

    // Reset in the middle of a frame, then a foreign busy after release
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("rm_gnt", 32'(bus.gnt), 32'(4'b0100));
    bus.req = 4'b0000;
    step();
    chk("rm_start", 32'(bus.tx_start), 32'(1));
    bus.tx_busy = 1'b1;
    repeat (3) step();
    chk("rm_active_in_frame", 32'(bus.active), 32'(1));
    rst_n   = 1'b0;
    bus.req = 4'b0100;
    step();
    chk("rm_all_zero",
        32'({bus.gnt, bus.tx_start, bus.tx_data, bus.active, bus.cur_id, bus.err_timeout}),
        32'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rm_blocked_c%0d", c), 32'({bus.gnt, bus.tx_start, bus.active}), 32'(0));
    end
    bus.tx_busy = 1'b0;
    step();
    chk("rm_gnt_after_busy", 32'(bus.gnt), 32'(4'b0100));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
